// File: rtl/debug_ocimem_port.sv
// debug_ocimem_port: debug monitor memory and register stage.
// It takes the JTAG command strobes and the 38-bit jdo word, reads and writes
// a small on-chip debug RAM shared with the CPU's Avalon debug-memory port,
// and returns MonDReg, monitor_ready and monitor_error for JTAG readback.
// Optional feature macro: DEBUG_MEM_PROTECT_EN. When it is defined, CPU
// writes only land while debugack=1. When it is undefined, debugack is
// ignored and CPU writes always land.
module debug_ocimem_port #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic              debugack,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    input  logic [3:0]        avs_byteenable,
    output logic [31:0]       avs_readdata,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        J_RD_WAIT = 2'd1,
        J_RD_CAP  = 2'd2,
        J_WR_WAIT = 2'd3
    } state_e;

    state_e              state_q;
    logic [ADDR_W-1:0]   monAddr_q;
    logic [31:0]         monData_q;
    logic                ready_q;
    logic                error_q;
    logic                error_d;
    logic                rdInc_q;
    logic [31:0]         jRdData_q;
    logic [31:0]         avsRdData_q;
    logic [31:0]         mem_q [2**ADDR_W];

    logic                anyStrobe;
    logic                multiStrobe;
    logic                acceptA;
    logic                acceptB;
    logic                acceptN;
    logic                cpuBusy;
    logic                cpuWrEn;
    logic                jRead;
    logic                jWrite;
    logic [5:0]          unused_bits;

    // jdo bits outside the used fields (and debugack in the unprotected build)
    assign unused_bits = {jdo[37:36], jdo[2:0], debugack};

    // Strobe decode: priority a > b > no_action, and error detection
    always_comb begin
        anyStrobe   = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
        multiStrobe = (take_action_ocimem_a & take_action_ocimem_b)
                    | (take_action_ocimem_a & take_no_action_ocimem_a)
                    | (take_action_ocimem_b & take_no_action_ocimem_a);
        acceptA     = ready_q & take_action_ocimem_a;
        acceptB     = ready_q & take_action_ocimem_b & ~take_action_ocimem_a;
        acceptN     = ready_q & take_no_action_ocimem_a & ~take_action_ocimem_a
                    & ~take_action_ocimem_b;
        error_d     = error_q;
        if (anyStrobe && (!ready_q || multiStrobe)) begin
            error_d = 1'b1;
        end else if (acceptA && jdo[33]) begin
            error_d = 1'b0;
        end
    end

    // Port arbitration: the CPU always owns the RAM port when it asks for it
    always_comb begin
        cpuBusy = avs_read | avs_write;
`ifdef DEBUG_MEM_PROTECT_EN
        cpuWrEn = avs_write & debugack;
`else
        cpuWrEn = avs_write;
`endif
        jRead   = (state_q == J_RD_WAIT) && !cpuBusy;
        jWrite  = (state_q == J_WR_WAIT) && !cpuBusy && !reset;
    end

    // Debug RAM array: CPU byte-lane writes, JTAG full-word writes and JTAG read capture
    always_ff @(posedge clk) begin
        if (cpuWrEn) begin
            for (int b = 0; b < 4; b++) begin
                if (avs_byteenable[b]) begin
                    mem_q[avs_address][8*b +: 8] <= avs_writedata[8*b +: 8];
                end
            end
        end else if (jWrite) begin
            mem_q[monAddr_q] <= monData_q;
        end
        if (jRead) begin
            jRdData_q <= mem_q[monAddr_q];
        end
    end

    // CPU read data register: one-cycle read latency, returns pre-write data
    always_ff @(posedge clk) begin
        if (reset) begin
            avsRdData_q <= 32'd0;
        end else if (avs_read) begin
            avsRdData_q <= mem_q[avs_address];
        end
    end

    // JTAG monitor FSM with registered address, data, ready and error
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            monAddr_q <= '0;
            monData_q <= 32'd0;
            ready_q   <= 1'b1;
            error_q   <= 1'b0;
            rdInc_q   <= 1'b0;
        end else begin
            error_q <= error_d;
            case (state_q)
                IDLE: begin
                    if (acceptA) begin
                        monAddr_q <= jdo[17 +: ADDR_W];
                        if (jdo[35]) begin
                            state_q <= J_RD_WAIT;
                            ready_q <= 1'b0;
                            rdInc_q <= 1'b0;
                        end
                    end else if (acceptB) begin
                        monData_q <= jdo[34:3];
                        state_q   <= J_WR_WAIT;
                        ready_q   <= 1'b0;
                    end else if (acceptN) begin
                        state_q <= J_RD_WAIT;
                        ready_q <= 1'b0;
                        rdInc_q <= 1'b1;
                    end
                end
                J_RD_WAIT: begin
                    if (!cpuBusy) begin
                        state_q <= J_RD_CAP;
                    end
                end
                J_RD_CAP: begin
                    monData_q <= jRdData_q;
                    if (rdInc_q) begin
                        monAddr_q <= monAddr_q + 1'b1;
                    end
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
                J_WR_WAIT: begin
                    if (!cpuBusy) begin
                        monAddr_q <= monAddr_q + 1'b1;
                        state_q   <= IDLE;
                        ready_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign avs_readdata  = avsRdData_q;
    assign MonDReg       = monData_q;
    assign monitor_ready = ready_q;
    assign monitor_error = error_q;

endmodule

// File: tb/tb_debug_ocimem_port.sv
// tb_debug_ocimem_port: directed plus randomized bench for debug_ocimem_port.
// A transaction-level model (word array, monitor address/data, error flag)
// predicts every observed value; DEBUG_MEM_PROTECT_EN selects the CPU write rule.
module tb_debug_ocimem_port;

    logic        clk;
    logic        reset;
    logic [37:0] jdo;
    logic        take_action_ocimem_a;
    logic        take_action_ocimem_b;
    logic        take_no_action_ocimem_a;
    logic        debugack;
    logic [7:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [3:0]  avs_byteenable;
    logic [31:0] avs_readdata;
    logic [31:0] MonDReg;
    logic        monitor_ready;
    logic        monitor_error;

`ifdef DEBUG_MEM_PROTECT_EN
    localparam bit PROTECT_ON = 1'b1;
`else
    localparam bit PROTECT_ON = 1'b0;
`endif

    int          nChecks = 0;
    int          nFails  = 0;

    logic [31:0] modelMem [256];
    logic [7:0]  modelAddr;
    logic [31:0] modelData;
    logic        modelErr;

    debug_ocimem_port #(.ADDR_W(8)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .debugack                (debugack),
        .avs_address             (avs_address),
        .avs_read                (avs_read),
        .avs_write               (avs_write),
        .avs_writedata           (avs_writedata),
        .avs_byteenable          (avs_byteenable),
        .avs_readdata            (avs_readdata),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFails++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cpuWrite(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
        avs_address    = a;
        avs_writedata  = d;
        avs_byteenable = be;
        avs_write      = 1'b1;
        tick();
        avs_write = 1'b0;
        if (!(PROTECT_ON && !debugack)) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) modelMem[a][8*b +: 8] = d[8*b +: 8];
            end
        end
    endtask

    task automatic cpuRead(input logic [7:0] a, input string tag);
        avs_address = a;
        avs_read    = 1'b1;
        tick();
        avs_read = 1'b0;
        checkOutput(tag, avs_readdata, modelMem[a]);
    endtask

    // kind 0 = ocimem_a, 1 = ocimem_b, 2 = no_action_a; contend = CPU read cycles after strobe
    task automatic applyStimulus(input int kind, input logic [7:0] addr, input logic [31:0] data,
                                 input bit rdFlag, input bit clrFlag, input int contend, input string tag);
        logic [37:0] j;
        bit          pend;
        bit          isRd;
        bit          inc;
        bit          rdPend;
        int          doneT;
        logic [7:0]  ra;
        logic [31:0] expRd;
        j = {6'($urandom), 32'($urandom)};
        pend = 1'b0;
        isRd = 1'b0;
        inc  = 1'b0;
        case (kind)
            0: begin
                j[24:17] = addr;
                j[35]    = rdFlag;
                j[33]    = clrFlag;
                take_action_ocimem_a = 1'b1;
                modelAddr = addr;
                if (clrFlag) modelErr = 1'b0;
                pend = rdFlag;
                isRd = 1'b1;
            end
            1: begin
                j[34:3] = data;
                take_action_ocimem_b = 1'b1;
                modelData = data;
                pend = 1'b1;
            end
            default: begin
                take_no_action_ocimem_a = 1'b1;
                pend = 1'b1;
                isRd = 1'b1;
                inc  = 1'b1;
            end
        endcase
        jdo = j;
        tick();
        take_action_ocimem_a    = 1'b0;
        take_action_ocimem_b    = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        if (!pend) begin
            checkOutput({tag, "_ready"}, 32'(monitor_ready), 32'd1);
            checkOutput({tag, "_err"}, 32'(monitor_error), 32'(modelErr));
            return;
        end
        doneT = (isRd ? 3 : 2) + contend;
        for (int t = 1; t < doneT; t++) begin
            checkOutput({tag, "_busy"}, 32'(monitor_ready), 32'd0);
            rdPend = 1'b0;
            if (t <= contend) begin
                ra          = 8'($urandom);
                avs_address = ra;
                avs_read    = 1'b1;
                expRd       = modelMem[ra];
                rdPend      = 1'b1;
            end
            tick();
            avs_read = 1'b0;
            if (rdPend) checkOutput({tag, "_cpurd"}, avs_readdata, expRd);
        end
        if (isRd) begin
            modelData = modelMem[modelAddr];
            if (inc) modelAddr = modelAddr + 8'd1;
        end else begin
            modelMem[modelAddr] = modelData;
            modelAddr = modelAddr + 8'd1;
        end
        checkOutput({tag, "_ready"}, 32'(monitor_ready), 32'd1);
        checkOutput({tag, "_mondreg"}, MonDReg, modelData);
        checkOutput({tag, "_err"}, 32'(monitor_error), 32'(modelErr));
    endtask

    initial begin
        logic [31:0] oldW;
        logic [31:0] expOld;
        reset = 1'b1;
        jdo = '0;
        take_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        debugack = 1'b1;
        avs_address = '0;
        avs_read = 1'b0;
        avs_write = 1'b0;
        avs_writedata = '0;
        avs_byteenable = 4'hF;
        modelAddr = '0;
        modelData = '0;
        modelErr = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        checkOutput("rst_mondreg", MonDReg, 32'd0);
        checkOutput("rst_ready", 32'(monitor_ready), 32'd1);
        checkOutput("rst_err", 32'(monitor_error), 32'd0);
        checkOutput("rst_readdata", avs_readdata, 32'd0);

        // Fill the RAM through the CPU port so every word is known
        for (int i = 0; i < 256; i++) cpuWrite(8'(i), $urandom, 4'hF);
        cpuRead(8'h00, "init_rd0");
        cpuRead(8'h10, "init_rd10");

        // JTAG write then read-back at 0x10
        applyStimulus(0, 8'h10, 32'd0, 1'b0, 1'b0, 0, "seta10");
        applyStimulus(1, 8'h00, 32'hDEADBEEF, 1'b0, 1'b0, 0, "wr_beef");
        cpuRead(8'h10, "cpu_sees_beef");
        applyStimulus(0, 8'h10, 32'd0, 1'b1, 1'b0, 0, "ard_10");
        applyStimulus(2, 8'h00, 32'd0, 1'b0, 1'b0, 0, "nard_10");
        applyStimulus(2, 8'h00, 32'd0, 1'b0, 1'b0, 0, "nard_11");

        // JTAG read under 3 cycles of CPU reads
        applyStimulus(0, 8'h10, 32'd0, 1'b1, 1'b0, 3, "ard_cont3");
        applyStimulus(1, 8'h00, 32'h13579BDF, 1'b0, 1'b0, 2, "wr_cont2");

        // Address wrap at 0xFF
        applyStimulus(0, 8'hFF, 32'd0, 1'b0, 1'b0, 0, "setaFF");
        applyStimulus(1, 8'h00, 32'h00000001, 1'b0, 1'b0, 0, "wr_wrap");
        applyStimulus(2, 8'h00, 32'd0, 1'b0, 1'b0, 0, "nard_wrap0");
        cpuRead(8'hFF, "cpu_rdFF");

        // Byte enables and read+write in the same cycle
        cpuWrite(8'h30, 32'hA1B2C3D4, 4'b0101);
        cpuRead(8'h30, "cpu_be");
        avs_address = 8'h31;
        avs_writedata = 32'hCAFEF00D;
        avs_byteenable = 4'hF;
        avs_read = 1'b1;
        avs_write = 1'b1;
        expOld = modelMem[8'h31];
        tick();
        avs_read = 1'b0;
        avs_write = 1'b0;
        checkOutput("cpu_rdwr_old", avs_readdata, expOld);
        modelMem[8'h31] = 32'hCAFEF00D;
        cpuRead(8'h31, "cpu_rdwr_new");

        // JTAG read issued right after a CPU write to the same word
        jdo = '0;
        jdo[24:17] = 8'h40;
        jdo[35] = 1'b1;
        take_action_ocimem_a = 1'b1;
        avs_address = 8'h40;
        avs_writedata = 32'h0BADC0DE;
        avs_byteenable = 4'hF;
        avs_write = 1'b1;
        tick();
        take_action_ocimem_a = 1'b0;
        avs_write = 1'b0;
        modelMem[8'h40] = 32'h0BADC0DE;
        modelAddr = 8'h40;
        modelData = 32'h0BADC0DE;
        tick();
        tick();
        checkOutput("rd_after_cpuwr", MonDReg, modelData);
        checkOutput("rd_after_cpuwr_ready", 32'(monitor_ready), 32'd1);

        // ocimem_b while busy is dropped and flags an error
        take_no_action_ocimem_a = 1'b1;
        tick();
        take_no_action_ocimem_a = 1'b0;
        jdo = '0;
        jdo[34:3] = 32'hBADBAD01;
        take_action_ocimem_b = 1'b1;
        tick();
        take_action_ocimem_b = 1'b0;
        modelErr = 1'b1;
        checkOutput("busy_err", 32'(monitor_error), 32'd1);
        tick();
        modelData = modelMem[modelAddr];
        modelAddr = modelAddr + 8'd1;
        checkOutput("busy_mondreg", MonDReg, modelData);
        checkOutput("busy_ready", 32'(monitor_ready), 32'd1);

        // ocimem_a and ocimem_b together: a wins, b dropped
        applyStimulus(0, 8'h00, 32'd0, 1'b0, 1'b1, 0, "clr1");
        jdo = '0;
        jdo[24:17] = 8'h50;
        take_action_ocimem_a = 1'b1;
        take_action_ocimem_b = 1'b1;
        tick();
        take_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
        modelAddr = 8'h50;
        modelErr = 1'b1;
        checkOutput("ab_err", 32'(monitor_error), 32'd1);
        checkOutput("ab_ready", 32'(monitor_ready), 32'd1);
        checkOutput("ab_mondreg", MonDReg, modelData);
        applyStimulus(2, 8'h00, 32'd0, 1'b0, 1'b0, 0, "ab_rd50");

        // Clear with a new error in the same cycle: error wins
        jdo = '0;
        jdo[24:17] = 8'h60;
        jdo[33] = 1'b1;
        take_action_ocimem_a = 1'b1;
        take_no_action_ocimem_a = 1'b1;
        tick();
        take_action_ocimem_a = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        modelAddr = 8'h60;
        checkOutput("clr_vs_err", 32'(monitor_error), 32'd1);
        applyStimulus(0, 8'h60, 32'd0, 1'b0, 1'b1, 0, "clr2");

        // Reset during a contended J_WR_WAIT cancels the write
        applyStimulus(0, 8'h70, 32'd0, 1'b0, 1'b0, 0, "seta70");
        oldW = modelMem[8'h70];
        jdo = '0;
        jdo[34:3] = ~oldW;
        take_action_ocimem_b = 1'b1;
        tick();
        take_action_ocimem_b = 1'b0;
        avs_address = 8'h70;
        avs_read = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        avs_read = 1'b0;
        modelAddr = '0;
        modelData = '0;
        modelErr = 1'b0;
        checkOutput("rstwr_ready", 32'(monitor_ready), 32'd1);
        checkOutput("rstwr_mondreg", MonDReg, 32'd0);
        checkOutput("rstwr_err", 32'(monitor_error), 32'd0);
        applyStimulus(0, 8'h70, 32'd0, 1'b1, 1'b0, 0, "rstwr_word");

        // CPU write with debugack low; JTAG write with debugack low
        debugack = 1'b0;
        cpuWrite(8'h20, 32'h5A5A5A5A, 4'hF);
        cpuRead(8'h20, "prot_cpu");
        applyStimulus(0, 8'h21, 32'd0, 1'b0, 1'b0, 0, "prot_seta");
        applyStimulus(1, 8'h00, 32'h77665544, 1'b0, 1'b0, 0, "prot_jwr");
        cpuRead(8'h21, "prot_jwr_cpu");
        debugack = 1'b1;

        // Randomized mix of CPU and JTAG traffic
        for (int k = 0; k < 30; k++) begin
            case ($urandom_range(0, 4))
                0: cpuWrite(8'($urandom), $urandom, 4'($urandom));
                1: cpuRead(8'($urandom), "rand_cpurd");
                2: applyStimulus(0, 8'($urandom), 32'd0, 1'b1, 1'b0, int'($urandom_range(0, 3)), "rand_ard");
                3: applyStimulus(1, 8'h00, $urandom, 1'b0, 1'b0, int'($urandom_range(0, 3)), "rand_wr");
                default: applyStimulus(2, 8'h00, 32'd0, 1'b0, 1'b0, int'($urandom_range(0, 3)), "rand_nard");
            endcase
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/debug_ocimem_port.md
Name: debug_ocimem_port

Overview:
- Debug monitor memory and register stage directly downstream of the debug-slave wrapper.
- Consumes the system-clock-domain command strobes and the 38-bit jdo word produced by the sysclk stage.
- Performs word reads and writes into a small on-chip debug RAM that is shared with the CPU's Avalon debug-memory slave port.
- Returns MonDReg, monitor_ready and monitor_error upstream for JTAG readback.

Parameters:
- ADDR_W, 8, debug RAM word-address width; depth is 2^ADDR_W words of 32 bits.

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- jdo  in  38  JTAG data word from the sysclk stage.
- take_action_ocimem_a  in  1  strobe: load address / control.
- take_action_ocimem_b  in  1  strobe: write jdo[34:3] at MonAReg, then post-increment.
- take_no_action_ocimem_a  in  1  strobe: read at MonAReg, then post-increment.
- debugack  in  1  CPU is in debug mode.
- avs_address  in  ADDR_W  CPU word address.
- avs_read  in  1  CPU read request.
- avs_write  in  1  CPU write request.
- avs_writedata  in  32  CPU write data.
- avs_byteenable  in  4  CPU byte lanes.
- avs_readdata  out  32  CPU read data, fixed read latency 1.
- MonDReg  out  32  monitor data register.
- monitor_ready  out  1  high when no JTAG operation is pending.
- monitor_error  out  1  sticky protocol error.

Behaviour:
- Reset values: MonDReg=0, MonAReg=0, monitor_ready=1, monitor_error=0, avs_readdata=0. FSM goes to IDLE. Any pending JTAG operation is cancelled with no RAM write. RAM contents are not cleared.
- jdo fields on take_action_ocimem_a:
  - MonAReg <= jdo[17+ADDR_W-1:17].
  - jdo[35]=1 also queues a read at the new address.
  - jdo[33]=1 clears monitor_error. A new error in the same cycle wins.
- take_action_ocimem_b: MonDReg <= jdo[34:3] in the strobe cycle, and a full-word write is queued.
- take_no_action_ocimem_a: queues a read.
- Simultaneous strobes: priority is ocimem_a > ocimem_b > no_action_a. Lower-priority strobes are dropped and monitor_error is set.
- Any strobe in a cycle where monitor_ready=0 is ignored and sets monitor_error.
- FSM states:
  - IDLE -> J_RD_WAIT or J_WR_WAIT on a queuing strobe; monitor_ready drops in the following cycle.
  - J_RD_WAIT: issue the RAM read in the first cycle with avs_read=0 and avs_write=0 (the CPU always owns the port when it requests); then -> J_RD_CAP.
  - J_RD_CAP: MonDReg <= RAM output; MonAReg <= MonAReg+1 (only for a no_action read; an ocimem_a read does not increment); -> IDLE, monitor_ready=1.
  - J_WR_WAIT: issue the write in the first free cycle; MonAReg <= MonAReg+1; -> IDLE.
- Latency without contention:
  - Strobe at cycle N, read issued at N+1, MonDReg and monitor_ready valid at N+3.
  - Write committed at N+1, monitor_ready=1 at N+2.
  - Each contended cycle adds 1 cycle.
- MonAReg increments modulo 2^ADDR_W: all-ones wraps to 0 with no error.
- CPU side:
  - avs_readdata is registered and valid exactly 1 cycle after avs_read.
  - Writes honour avs_byteenable.
  - avs_read and avs_write together: the write is performed, readdata returns the pre-write (old) data.
  - No waitrequest; the CPU is never stalled.
- Same-cycle port use is impossible, because the JTAG side yields. A JTAG read issued in the cycle after a CPU write to the same address returns the new data.

Optional Feature:
- DEBUG_MEM_PROTECT_EN.
- Defined: CPU writes (avs_write) take effect only while debugack=1; otherwise they are silently dropped. JTAG writes are unaffected.
- Undefined: debugack is ignored and CPU writes are always performed.

Test Plan:
- ocimem_a with jdo[17+:8]=0x10, jdo[35]=0, then ocimem_b with jdo[34:3]=0xDEADBEEF -> RAM[0x10]=0xDEADBEEF, MonAReg=0x11, monitor_ready high 2 cycles after the strobe.
- ocimem_a at address 0x10 with jdo[35]=1 -> MonDReg=0xDEADBEEF at N+3, MonAReg stays 0x10. Then no_action_a -> MonDReg=RAM[0x10], MonAReg=0x11.
- Queue a JTAG read while avs_read is held for 3 cycles -> MonDReg valid at N+6. CPU readdata is correct every cycle.
- MonAReg=0xFF, ocimem_b with 0x1 -> RAM[0xFF]=1, MonAReg wraps to 0x00, monitor_error stays 0.
- ocimem_b while busy, or ocimem_a+ocimem_b in the same cycle -> monitor_error=1 and the extra/blocked write is not performed. ocimem_a with jdo[33]=1 -> monitor_error=0.
- Reset asserted during J_WR_WAIT under CPU contention -> target word unchanged, monitor_ready=1, MonDReg=0. With DEBUG_MEM_PROTECT_EN and debugack=0, a CPU write of 0x5A5A5A5A is ignored.
